// File: rtl/tlc_timer.sv
// Countdown timer for the traffic-light controller: prescaled tick, loadable count,
// hold/freeze, and a registered done flag that is never stale after a load.
module tlc_timer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_rst,
  input  logic [CNT_W-1:0] wait_cnt,
  input  logic             hold,
  output logic             cntr_done,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] remaining
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [PW-1:0]    presc_r;
  logic [PW-1:0]    presc_s;
  logic [CNT_W-1:0] rem_s;
  logic             tick_s;

  // State, prescaler and registered outputs; outputs decode the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      presc_r   <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      cntr_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      presc_r   <= presc_s;
      remaining <= rem_s;
      tick      <= tick_s;
      cntr_done <= (state_s == ST_DONE);
      busy      <= (state_s == ST_RUN);
    end
  end

  // Next-state logic: a load overrides hold and any pending tick edge.
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    rem_s   = remaining;
    tick_s  = 1'b0;
    if (cnt_rst) begin
      rem_s   = wait_cnt;
      presc_s = '0;
      state_s = (wait_cnt != '0) ? ST_RUN : ST_DONE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hold) begin
            presc_s = presc_r;
          end else if (presc_r == PRESC_MAX) begin
            presc_s = '0;
            rem_s   = remaining - CNT_W'(1);
            tick_s  = 1'b1;
            if (remaining == CNT_W'(1)) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            presc_s = presc_r + PW'(1);
          end
        end
        ST_IDLE: state_s = ST_IDLE;
        ST_DONE: state_s = ST_DONE;
        default: begin
          state_s = ST_IDLE;
          presc_s = '0;
          rem_s   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_timer.sv
// Self-checking bench for tlc_timer: directed latency scenarios plus random stimulus,
// all checked against an arithmetic reference (count = W - advances/TICK_DIV).
module tb_tlc_timer;
  localparam int TD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_rst;
  logic [CW-1:0] wait_cnt;
  logic          hold;
  logic          cntr_done;
  logic          busy;
  logic          tick;
  logic [CW-1:0] remaining;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference: loaded value and number of non-held RUN cycles since that load.
  bit m_loaded = 1'b0;
  int m_w      = 0;
  int m_adv    = 0;
  bit m_tick   = 1'b0;

  tlc_timer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cnt_rst(cnt_rst), .wait_cnt(wait_cnt), .hold(hold),
    .cntr_done(cntr_done), .busy(busy), .tick(tick), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic int exp_rem();
    return m_loaded ? (m_w - m_adv / TD) : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_loaded = 1'b0; m_w = 0; m_adv = 0; m_tick = 1'b0;
    end else if (cnt_rst) begin
      m_loaded = 1'b1; m_w = int'(wait_cnt); m_adv = 0; m_tick = 1'b0;
    end else if (m_loaded && exp_rem() > 0 && !hold) begin
      m_adv++;
      m_tick = (m_adv % TD == 0);
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("cntr_done", 32'(cntr_done), 32'(m_loaded && exp_rem() == 0));
    chk("busy",      32'(busy),      32'(m_loaded && exp_rem() > 0));
    chk("tick",      32'(tick),      32'(m_tick));
    chk("remaining", 32'(remaining), 32'(exp_rem()));
  endtask

  task automatic load(input int w);
    cnt_rst = 1'b1; wait_cnt = CW'(w);
    step();
    cnt_rst = 1'b0;
  endtask

  task automatic run_until_done(input int n0, input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      if (cntr_done) begin
        lat = cyc - n0;
        break;
      end
      step();
    end
  endtask

  initial begin
    int n0;
    int lat;
    int last_load;
    int idx;
    int nint;
    int ph_w[4]   = '{12, 3, 12, 3};
    int ph_len[3] = '{49, 13, 49};

    rst = 1'b1; cnt_rst = 1'b0; wait_cnt = '0; hold = 1'b0;
    #1;
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    // Basic count W=3: done at N+13
    n0 = cyc; load(3);
    run_until_done(n0, 100, lat);
    chk("lat_w3", 32'(lat), 32'd13);
    repeat (5) step();
    chk("done_held", 32'(cntr_done), 32'd1);

    // Zero and max load
    n0 = cyc; load(0);
    chk("lat_w0", 32'(cyc - n0), 32'd1);
    chk("w0_busy", 32'(busy), 32'd0);
    n0 = cyc; load(15);
    run_until_done(n0, 200, lat);
    chk("lat_w15", 32'(lat), 32'd61);

    // Hold for cycles N+3..N+7
    n0 = cyc; load(2);
    repeat (2) step();
    hold = 1'b1;
    repeat (5) step();
    chk("hold_frozen", 32'(remaining), 32'd2);
    hold = 1'b0;
    run_until_done(n0, 100, lat);
    chk("lat_hold", 32'(lat), 32'd14);

    // Reload on a tick-edge cycle while remaining=2
    load(5);
    for (int i = 0; i < 100 && m_adv != 15; i++) step();
    chk("pre_reload_rem", 32'(remaining), 32'd2);
    n0 = cyc; load(3);
    chk("reload_rem", 32'(remaining), 32'd3);
    run_until_done(n0, 100, lat);
    chk("lat_reload", 32'(lat), 32'd13);

    // Load together with hold
    hold = 1'b1; load(7);
    chk("load_hold_busy", 32'(busy), 32'd1);
    chk("load_hold_rem", 32'(remaining), 32'd7);
    hold = 1'b0;

    // Reset mid-count
    load(9);
    repeat (10) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_rem", 32'(remaining), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (5) step();

    // Controller loop: reload immediately whenever done is seen
    last_load = cyc; load(ph_w[0]);
    idx = 1; nint = 0;
    for (int i = 0; i < 400 && nint < 3; i++) begin
      cnt_rst = cntr_done;
      wait_cnt = CW'(ph_w[idx]);
      if (cntr_done) begin
        chk("phase_len", 32'(cyc - last_load), 32'(ph_len[nint]));
        last_load = cyc;
        nint++;
        idx++;
      end
      step();
    end
    cnt_rst = 1'b0;
    chk("phases_seen", 32'(nint), 32'd3);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(199) == 0);
      cnt_rst  = ($urandom_range(39) == 0);
      wait_cnt = CW'($urandom);
      hold     = ($urandom_range(3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
